// File: rtl/work_issuer.sv
`default_nettype none
// ============================================================================
// Module      : work_issuer
// Description : Walks a rectangular pixel frame through external x/y counters.
//               For each pixel it computes the plane coordinate and offers it
//               as a job over a valid/ready handshake.
//               Optional feature macro: WORK_ISSUER_TAG_EN adds a 16-bit
//               job_tag output that numbers the jobs within a frame.
// Revision    : 1.0 - initial release
// ============================================================================
module work_issuer #(
    parameter int NUM_X_BITS = 4,
    parameter int NUM_Y_BITS = 4,
    parameter int FP_BITS    = 32
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_X_BITS-1:0] x_max,
    input  logic [NUM_Y_BITS-1:0] y_max,
    input  logic [FP_BITS-1:0]    re_origin,
    input  logic [FP_BITS-1:0]    im_origin,
    input  logic [FP_BITS-1:0]    re_step,
    input  logic [FP_BITS-1:0]    im_step,
    input  logic [NUM_X_BITS-1:0] x_count,
    input  logic [NUM_Y_BITS-1:0] y_count,
    output logic                  x_count_enable,
    output logic                  y_count_enable,
    output logic                  x_clear,
    output logic                  y_clear,
    output logic                  job_valid,
    input  logic                  job_ready,
    output logic [NUM_X_BITS-1:0] job_x,
    output logic [NUM_Y_BITS-1:0] job_y,
    output logic [FP_BITS-1:0]    job_re,
    output logic [FP_BITS-1:0]    job_im,
    output logic                  busy,
    output logic                  done
`ifdef WORK_ISSUER_TAG_EN
    ,
    output logic [15:0]           job_tag
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ISSUE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;

    // Frame registers, captured on an accepted start
    logic [NUM_X_BITS-1:0]   r_x_max;
    logic [NUM_Y_BITS-1:0]   r_y_max;
    logic [FP_BITS-1:0]      r_re_origin;
    logic [FP_BITS-1:0]      r_im_origin;
    logic [FP_BITS-1:0]      r_re_step;
    logic [FP_BITS-1:0]      r_im_step;

    // Registered outputs
    logic                    r_job_valid;
    logic [NUM_X_BITS-1:0]   r_job_x;
    logic [NUM_Y_BITS-1:0]   r_job_y;
    logic [FP_BITS-1:0]      r_job_re;
    logic [FP_BITS-1:0]      r_job_im;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_start_ok;
    logic                    w_accept;
    logic                    w_x_last;
    logic                    w_y_last;
    logic [FP_BITS-1:0]      w_x_ext;
    logic [FP_BITS-1:0]      w_y_ext;
    logic [FP_BITS-1:0]      w_re_calc;
    logic [FP_BITS-1:0]      w_im_calc;

    // abort suppresses both a start and an acceptance in the same cycle, so
    // no counter pulse can escape while the frame is being cancelled.
    assign w_start_ok = (r_state == S_IDLE) && start && !abort;
    assign w_accept   = (r_state == S_ISSUE) && r_job_valid && job_ready && !abort;
    assign w_x_last   = (r_job_x == r_x_max);
    assign w_y_last   = (r_job_y == r_y_max);

    // Counter handshakes are combinational so the counters step on the same
    // edge that retires the job; LOAD then sees the new coordinate.
    assign x_count_enable = w_accept && !w_x_last;
    assign y_count_enable = w_accept && w_x_last && !w_y_last;
    assign x_clear        = w_start_ok || (w_accept && w_x_last && !w_y_last);
    assign y_clear        = w_start_ok;

    // Plane coordinate; products and sums wrap modulo 2^FP_BITS
    assign w_x_ext   = FP_BITS'(x_count);
    assign w_y_ext   = FP_BITS'(y_count);
    assign w_re_calc = r_re_origin + r_re_step * w_x_ext;
    assign w_im_calc = r_im_origin + r_im_step * w_y_ext;

    assign job_valid = r_job_valid;
    assign job_x     = r_job_x;
    assign job_y     = r_job_y;
    assign job_re    = r_job_re;
    assign job_im    = r_job_im;
    assign busy      = r_busy;
    assign done      = r_done;

    // Frame sequencer with registered payload and status outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= S_IDLE;
            r_x_max     <= '0;
            r_y_max     <= '0;
            r_re_origin <= '0;
            r_im_origin <= '0;
            r_re_step   <= '0;
            r_im_step   <= '0;
            r_job_valid <= 1'b0;
            r_job_x     <= '0;
            r_job_y     <= '0;
            r_job_re    <= '0;
            r_job_im    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state     <= S_IDLE;
                r_job_valid <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_x_max     <= x_max;
                            r_y_max     <= y_max;
                            r_re_origin <= re_origin;
                            r_im_origin <= im_origin;
                            r_re_step   <= re_step;
                            r_im_step   <= im_step;
                            r_busy      <= 1'b1;
                            r_state     <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        r_job_x     <= x_count;
                        r_job_y     <= y_count;
                        r_job_re    <= w_re_calc;
                        r_job_im    <= w_im_calc;
                        r_job_valid <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                    S_ISSUE: begin
                        if (w_accept) begin
                            r_job_valid <= 1'b0;
                            if (w_x_last && w_y_last) begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_state <= S_LOAD;
                            end
                        end
                    end
                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef WORK_ISSUER_TAG_EN
    logic [15:0] r_job_tag;

    assign job_tag = r_job_tag;

    // Job sequence number: cleared per frame, advanced on every acceptance
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_job_tag <= '0;
        end else if (w_start_ok) begin
            r_job_tag <= '0;
        end else if (w_accept) begin
            r_job_tag <= r_job_tag + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_work_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_work_issuer
// Description : Directed self-checking bench for work_issuer; x/y counters
//               are modelled here and driven by the DUT's pulse outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_work_issuer;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start;
    logic        abort;
    logic [3:0]  x_max;
    logic [3:0]  y_max;
    logic [31:0] re_origin;
    logic [31:0] im_origin;
    logic [31:0] re_step;
    logic [31:0] im_step;
    logic [3:0]  x_count = 4'd3;
    logic [3:0]  y_count = 4'd2;
    logic        x_count_enable;
    logic        y_count_enable;
    logic        x_clear;
    logic        y_clear;
    logic        job_valid;
    logic        job_ready;
    logic [3:0]  job_x;
    logic [3:0]  job_y;
    logic [31:0] job_re;
    logic [31:0] job_im;
    logic        busy;
    logic        done;
`ifdef WORK_ISSUER_TAG_EN
    logic [15:0] job_tag;
    logic [15:0] jtag [8];
`endif

    int          n_cmp = 0;
    int          n_err = 0;

    // Per-frame record filled by run_frame
    int          n_jobs;
    int          done_cyc;
    int          n_xe;
    int          n_ye;
    logic [3:0]  jx  [8];
    logic [3:0]  jy  [8];
    logic [31:0] jre [8];
    logic [31:0] jim [8];

    work_issuer #(
        .NUM_X_BITS (4),
        .NUM_Y_BITS (4),
        .FP_BITS    (32)
    ) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .start          (start),
        .abort          (abort),
        .x_max          (x_max),
        .y_max          (y_max),
        .re_origin      (re_origin),
        .im_origin      (im_origin),
        .re_step        (re_step),
        .im_step        (im_step),
        .x_count        (x_count),
        .y_count        (y_count),
        .x_count_enable (x_count_enable),
        .y_count_enable (y_count_enable),
        .x_clear        (x_clear),
        .y_clear        (y_clear),
        .job_valid      (job_valid),
        .job_ready      (job_ready),
        .job_x          (job_x),
        .job_y          (job_y),
        .job_re         (job_re),
        .job_im         (job_im),
        .busy           (busy),
        .done           (done)
`ifdef WORK_ISSUER_TAG_EN
        ,
        .job_tag        (job_tag)
`endif
    );

    always #5 clk = ~clk;

    // External coordinate counters
    always @(posedge clk) begin
        if (x_clear)             x_count <= 4'd0;
        else if (x_count_enable) x_count <= x_count + 4'd1;
        if (y_clear)             y_count <= 4'd0;
        else if (y_count_enable) y_count <= y_count + 4'd1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start a frame and record every accepted job until done (bounded)
    task automatic run_frame(input logic [3:0] xm, input logic [3:0] ym,
                             input logic [31:0] ro, input logic [31:0] rs,
                             input logic [31:0] io, input logic [31:0] is_);
        x_max = xm; y_max = ym;
        re_origin = ro; re_step = rs; im_origin = io; im_step = is_;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_jobs = 0; done_cyc = -1; n_xe = 0; n_ye = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                done_cyc = c;
                check("busy_in_done", busy, 1);
                break;
            end
            if (job_valid && job_ready) begin
                if (n_jobs < 8) begin
                    jx[n_jobs] = job_x; jy[n_jobs] = job_y;
                    jre[n_jobs] = job_re; jim[n_jobs] = job_im;
`ifdef WORK_ISSUER_TAG_EN
                    jtag[n_jobs] = job_tag;
`endif
                end
                n_jobs++;
            end
            if (x_count_enable) n_xe++;
            if (y_count_enable) n_ye++;
            @(negedge clk);
        end
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   got;
        logic flag;
        n_rst = 1'b0; start = 1'b0; abort = 1'b0; job_ready = 1'b1;
        x_max = '0; y_max = '0;
        re_origin = '0; im_origin = '0; re_step = '0; im_step = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", job_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pulses", {x_count_enable, y_count_enable, x_clear, y_clear}, 0);
        check("rst_payload", {job_x, job_y, job_re, job_im} == '0, 1);
        n_rst = 1'b1;
        @(negedge clk);

        // 2x2 frame, unit steps
        run_frame(4'd1, 4'd1, 32'd0, 32'd1, 32'd0, 32'd1);
        check("f22_jobs", n_jobs, 4);
        for (int i = 0; i < 4; i++) begin
            check("f22_x",  jx[i],  i % 2);
            check("f22_y",  jy[i],  i / 2);
            check("f22_re", jre[i], i % 2);
            check("f22_im", jim[i], i / 2);
`ifdef WORK_ISSUER_TAG_EN
            check("f22_tag", jtag[i], i);
`endif
        end
        check("f22_done_cyc", done_cyc, 9);
        check("f22_xen", n_xe, 2);
        check("f22_yen", n_ye, 1);

        // Single-pixel frame
        run_frame(4'd0, 4'd0, 32'd0, 32'd1, 32'd0, 32'd1);
        check("f11_jobs", n_jobs, 1);
        check("f11_xy", {jx[0], jy[0]}, 0);
        check("f11_done_cyc", done_cyc, 3);
        check("f11_xen", n_xe, 0);
        check("f11_yen", n_ye, 0);

        // Fixed-point wrap and non-unit steps
        run_frame(4'd1, 4'd1, 32'h7FFF_FFFF, 32'd1, 32'h10, 32'h5);
        check("wrap_re0", jre[0], 32'h7FFF_FFFF);
        check("wrap_re1", jre[1], 32'h8000_0000);
        check("wrap_im2", jim[2], 32'h15);
        run_frame(4'd1, 4'd1, 32'd100, 32'hFFFF_FFFD, 32'd0, 32'd7);
        check("neg_re1", jre[1], 32'd97);
        check("neg_im3", jim[3], 32'd7);
        check("neg_x3", jx[3], 1);

        // Back-pressure: 5 stalled cycles, start ignored mid-frame
        job_ready = 1'b0;
        x_max = 4'd1; y_max = 4'd0;
        re_origin = 32'd100; re_step = 32'd3; im_origin = '0; im_step = 32'd1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("stall_load_valid", job_valid, 0);
        check("stall_load_busy", busy, 1);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", job_valid, 1);
            check("stall_x", job_x, 0);
            check("stall_re", job_re, 32'd100);
            check("stall_pulse", {x_count_enable, y_count_enable, x_clear, y_clear}, 0);
            if (k == 1) begin start = 1'b1; x_max = 4'd0; end
            if (k == 3) start = 1'b0;
            @(negedge clk);
        end
        job_ready = 1'b1;
        #1;
        check("stall_accept_xen", x_count_enable, 1);
        @(negedge clk);
        got = 0; flag = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (job_valid && job_ready) begin
                check("stall_job2_x", job_x, 1);
                check("stall_job2_re", job_re, 32'd103);
                got++;
            end
            if (done) begin flag = 1'b1; break; end
            @(negedge clk);
        end
        check("stall_job2_count", got, 1);
        check("stall_done_seen", flag, 1);
        repeat (2) @(negedge clk);

        // Abort during the third acceptance
        x_max = 4'd1; y_max = 4'd1;
        re_origin = '0; re_step = 32'd1; im_origin = '0; im_step = 32'd1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_job3", {job_valid, job_x, job_y}, {1'b1, 4'd0, 4'd1});
        abort = 1'b1;
        #1;
        check("abort_pulse", {x_count_enable, y_count_enable, x_clear, y_clear}, 0);
        @(negedge clk); abort = 1'b0;
        check("abort_valid", job_valid, 0);
        check("abort_busy", busy, 0);
        flag = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (done || job_valid) flag = 1'b1;
            @(negedge clk);
        end
        check("abort_quiet", flag, 0);
        run_frame(4'd1, 4'd1, 32'd0, 32'd1, 32'd0, 32'd1);
        check("abort_restart_xy", {jx[0], jy[0]}, 0);
        check("abort_restart_jobs", n_jobs, 4);

        // Reset mid-frame
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_before_x", job_x, 1);
        n_rst = 1'b0;
        #1;
        check("midrst_valid", job_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_x", job_x, 0);
        @(negedge clk); n_rst = 1'b1;
        check("midrst_done", done, 0);
        run_frame(4'd1, 4'd1, 32'd0, 32'd1, 32'd0, 32'd1);
        check("midrst_first_xy", {jx[0], jy[0]}, 0);
        check("midrst_done_cyc", done_cyc, 9);
`ifdef WORK_ISSUER_TAG_EN
        check("midrst_tag", jtag[0], 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
